// File: rtl/cmp_stim_sequencer.sv
// ============================================================================
// cmp_stim_sequencer : four-valued stimulus sequencer with chk/mismatch bookkeeping
// Revision: 1.0
// ============================================================================
`default_nettype none

module cmp_stim_sequencer #(
  parameter int          WIDTH        = 8,
  parameter int          ENUM_BITS    = 4,
  parameter int          RAND_PER_PAT = 50,
  parameter int          SETTLE_CYC   = 2,
  parameter logic [31:0] SEED         = 32'h1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_stop_on_fail,
  input  logic                   i_mismatch,
  output logic [WIDTH-1:0]       o_src1,
  output logic [WIDTH-1:0]       o_src2,
  output logic [WIDTH-1:0]       o_src3,
  output logic                   o_chk,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [15:0]            o_err_count,
  output logic [4*ENUM_BITS-1:0] o_fail_pat,
  output logic [15:0]            o_fail_vec
);

  localparam int                c_PW          = 4 * ENUM_BITS;
  localparam int                c_CNT_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [31:0]       c_TAPS        = 32'h80200003;
  localparam logic [15:0]       c_J_LAST      = 16'(RAND_PER_PAT - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_GAP, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_lfsr;
  logic [c_PW-1:0]    r_p;
  logic [15:0]        r_j;
  logic [c_CNT_W-1:0] r_cnt;
  logic [15:0]        r_err;
  logic               r_has_fail;
  logic               r_pass;
  logic [c_PW-1:0]    r_fail_pat;
  logic [15:0]        r_fail_vec;
  logic [WIDTH-1:0]   r_v1, r_x1, r_z1, r_v2, r_x2, r_z2, r_v3;

  logic               w_last, w_j_wrap, w_ld_seed, w_enter_done, w_pass_val;
  logic [15:0]        w_j_adv;
  logic [c_PW-1:0]    w_p_adv, w_ld_p;
  logic [WIDTH-1:0]   w_v1, w_x1, w_z1, w_v2, w_x2, w_z2, w_v3;

  function automatic logic [31:0] f_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? c_TAPS : 32'h0);
  endfunction

  assign w_last    = (&r_p) && (r_j == c_J_LAST);
  assign w_j_wrap  = (r_j == c_J_LAST);
  assign w_j_adv   = w_j_wrap ? 16'd0 : r_j + 16'd1;
  assign w_p_adv   = w_j_wrap ? r_p + 1'b1 : r_p;
  assign w_ld_seed = (r_state == S_IDLE);
  assign w_ld_p    = w_ld_seed ? '0 : w_p_adv;

  // Random fill from the LFSR, then the enumerated digits overwrite the low bits.
  always_comb begin
    w_v1 = w_ld_seed ? SEED[WIDTH-1:0]    : r_lfsr[WIDTH-1:0];
    w_v2 = w_ld_seed ? SEED[WIDTH+9:10]   : r_lfsr[WIDTH+9:10];
    w_v3 = w_ld_seed ? SEED[WIDTH+19:20]  : r_lfsr[WIDTH+19:20];
    w_x1 = '0;
    w_z1 = '0;
    w_x2 = '0;
    w_z2 = '0;
    for (int k = 0; k < ENUM_BITS; k++) begin
      w_v2[k] = (w_ld_p[2*k +: 2] == 2'd1);
      w_x2[k] = (w_ld_p[2*k +: 2] == 2'd2);
      w_z2[k] = (w_ld_p[2*k +: 2] == 2'd3);
      w_v1[k] = (w_ld_p[2*(k+ENUM_BITS) +: 2] == 2'd1);
      w_x1[k] = (w_ld_p[2*(k+ENUM_BITS) +: 2] == 2'd2);
      w_z1[k] = (w_ld_p[2*(k+ENUM_BITS) +: 2] == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_chk       = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        o_busy = 1'b1;
        if (i_abort)                     w_state_nxt = S_DONE;
        else if (r_cnt == c_SETTLE_LAST) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        o_busy = 1'b1;
        o_chk  = 1'b1;
        if (i_abort || (i_mismatch && i_stop_on_fail)) w_state_nxt = S_DONE;
        else                                           w_state_nxt = S_GAP;
      end
      S_GAP: begin
        o_busy = 1'b1;
        if (i_abort || w_last) w_state_nxt = S_DONE;
        else                   w_state_nxt = S_SETTLE;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (!i_start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);
  assign w_pass_val   = !i_abort && (r_err == 16'd0) && !((r_state == S_CHECK) && i_mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr     <= SEED;
      r_p        <= '0;
      r_j        <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_has_fail <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_pat <= '0;
      r_fail_vec <= '0;
      r_v1 <= '0; r_x1 <= '0; r_z1 <= '0;
      r_v2 <= '0; r_x2 <= '0; r_z2 <= '0;
      r_v3 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_err      <= '0;
          r_has_fail <= 1'b0;
          r_pass     <= 1'b0;
          r_fail_pat <= '0;
          r_fail_vec <= '0;
          r_p        <= '0;
          r_j        <= '0;
          r_cnt      <= '0;
          r_lfsr     <= f_step(SEED);
          r_v1 <= w_v1; r_x1 <= w_x1; r_z1 <= w_z1;
          r_v2 <= w_v2; r_x2 <= w_x2; r_z2 <= w_z2;
          r_v3 <= w_v3;
        end
        S_SETTLE: r_cnt <= r_cnt + 1'b1;
        S_CHECK: if (i_mismatch) begin
          r_err <= (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
          if (!r_has_fail) begin
            r_has_fail <= 1'b1;
            r_fail_pat <= r_p;
            r_fail_vec <= r_j;
          end
        end
        S_GAP: if (!i_abort && !w_last) begin
          r_p    <= w_p_adv;
          r_j    <= w_j_adv;
          r_cnt  <= '0;
          r_lfsr <= f_step(r_lfsr);
          r_v1 <= w_v1; r_x1 <= w_x1; r_z1 <= w_z1;
          r_v2 <= w_v2; r_x2 <= w_x2; r_z2 <= w_z2;
          r_v3 <= w_v3;
        end
        default: ;
      endcase
      if (w_enter_done) r_pass <= w_pass_val;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_src
      assign o_src1[i] = r_z1[i] ? 1'bz : (r_x1[i] ? 1'bx : r_v1[i]);
      assign o_src2[i] = r_z2[i] ? 1'bz : (r_x2[i] ? 1'bx : r_v2[i]);
    end
  endgenerate

  assign o_src3      = r_v3;
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_fail_pat  = r_fail_pat;
  assign o_fail_vec  = r_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_cmp_stim_sequencer.sv
// Testbench for cmp_stim_sequencer: scenario table, random mismatch runs, reset/abort/start corners.
`default_nettype none

module tb_cmp_stim_sequencer;

  localparam int          W    = 8;
  localparam int          EB   = 1;
  localparam int          RPP  = 2;
  localparam int          SC   = 2;
  localparam int          PER  = SC + 2;
  localparam int          NVEC = 32;
  localparam logic [31:0] SD   = 32'h1;

  logic        clk, rst, start, abort, stop_on_fail, mismatch;
  wire  [W-1:0] src1, src2, src3;
  logic        chk, busy, done, pass;
  logic [15:0] err_count, fail_vec;
  logic [3:0]  fail_pat;

  int n_vec = 0;
  int n_err = 0;

  cmp_stim_sequencer #(
    .WIDTH(W), .ENUM_BITS(EB), .RAND_PER_PAT(RPP), .SETTLE_CYC(SC), .SEED(SD)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_stop_on_fail(stop_on_fail), .i_mismatch(mismatch),
    .o_src1(src1), .o_src2(src2), .o_src3(src3),
    .o_chk(chk), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err_count), .o_fail_pat(fail_pat), .o_fail_vec(fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stop;
    logic [31:0] mm;
    int          ak;
    int          err;
    logic        pass;
    logic [3:0]  fp;
    logic [15:0] fv;
  } vec_t;

  vec_t tbl[8];

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Operands of vector n: LFSR advanced n times from the seed, enumerated digits of p=n/RPP.
  // m* marks bits expected to be 0/1 (X/Z positions are excluded from the compare).
  function automatic void exp_ops(input int n, output logic [W-1:0] e1, output logic [W-1:0] e2,
                                  output logic [W-1:0] e3, output logic [W-1:0] m1,
                                  output logic [W-1:0] m2);
    logic [31:0] l;
    int p, d0, d1;
    l = SD;
    for (int i = 0; i < n; i++) l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    e1 = l[W-1:0];
    e2 = l[W+9:10];
    e3 = l[W+19:20];
    m1 = '1;
    m2 = '1;
    p  = n / RPP;
    d0 = p % 4;
    d1 = (p / 4) % 4;
    if (d0 < 2) e2[0] = (d0 == 1); else m2[0] = 1'b0;
    if (d1 < 2) e1[0] = (d1 == 1); else m1[0] = 1'b0;
  endfunction

  function automatic void model(input logic stop, input logic [31:0] mm, input int ak,
                                output int e_err, output logic e_pass,
                                output logic [3:0] fp, output logic [15:0] fv);
    int lim, first;
    lim   = (ak >= 0) ? ak : NVEC;
    e_err = 0;
    first = -1;
    for (int n = 0; n < lim; n++)
      if (mm[n] && !(stop && first >= 0)) begin
        e_err++;
        if (first < 0) first = n;
      end
    e_pass = (ak < 0) && (e_err == 0);
    fp = (first >= 0) ? 4'(first / RPP) : 4'd0;
    fv = (first >= 0) ? 16'(first % RPP) : 16'd0;
  endfunction

  task automatic run(input logic stop, input logic [31:0] mm, input int ak, input int x_err,
                     input logic x_pass, input logic [3:0] x_fp, input logic [15:0] x_fv);
    int done_c, v;
    logic [2:0]   ectl;
    logic [W-1:0] e1, e2, e3, m1, m2;
    done_c = (ak >= 0) ? PER * ak + 1 : PER * NVEC;
    if (stop)
      for (int n = 0; n < NVEC; n++)
        if (mm[n] && (PER * n + SC + 1 < done_c)) done_c = PER * n + SC + 1;
    @(negedge clk);
    stop_on_fail = stop;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      if (c > 0) @(negedge clk);
      abort    = 1'b0;
      mismatch = 1'b0;
      if (c < done_c) begin
        ectl = {((c % PER) == SC), 1'b1, 1'b0};
        chk_eq("ctrl_run", {29'd0, chk, busy, done}, {29'd0, ectl});
        if ((c % PER) == SC) begin
          v = c / PER;
          exp_ops(v, e1, e2, e3, m1, m2);
          chk_eq("src1", 32'(src1 & m1), 32'(e1 & m1));
          chk_eq("src2", 32'(src2 & m2), 32'(e2 & m2));
          chk_eq("src3", 32'(src3), 32'(e3));
          mismatch = mm[v];
        end
        if (ak >= 0 && c == PER * ak) abort = 1'b1;
      end else begin
        chk_eq("ctrl_done", {29'd0, chk, busy, done}, 32'd1);
        chk_eq("err_count", 32'(err_count), 32'(x_err));
        chk_eq("pass", 32'(pass), 32'(x_pass));
        chk_eq("fail_pat", 32'(fail_pat), 32'(x_fp));
        chk_eq("fail_vec", 32'(fail_vec), 32'(x_fv));
      end
    end
    @(negedge clk);
    chk_eq("ctrl_idle", {29'd0, chk, busy, done}, 32'd0);
    chk_eq("err_hold", 32'(err_count), 32'(x_err));
    chk_eq("pass_hold", 32'(pass), 32'(x_pass));
  endtask

  initial begin
    int          r_err_e;
    logic        r_pass_e, r_stop;
    logic [3:0]  r_fp;
    logic [15:0] r_fv;
    logic [31:0] r_mm;
    int          r_ak;
    logic [W-1:0] e1, e2, e3, m1, m2;

    rst = 1'b1; start = 1'b0; abort = 1'b0; stop_on_fail = 1'b0; mismatch = 1'b0;

    tbl[0] = '{1'b0, 32'h0,          -1, 0, 1'b1, 4'd0,  16'd0};
    tbl[1] = '{1'b0, 32'h0000_0800,  -1, 1, 1'b0, 4'd5,  16'd1};
    tbl[2] = '{1'b1, 32'h0000_0800,  -1, 1, 1'b0, 4'd5,  16'd1};
    tbl[3] = '{1'b0, 32'h0,           2, 0, 1'b0, 4'd0,  16'd0};
    tbl[4] = '{1'b0, 32'h0010_0008,  -1, 2, 1'b0, 4'd1,  16'd1};
    tbl[5] = '{1'b1, 32'h0000_0001,  -1, 1, 1'b0, 4'd0,  16'd0};
    tbl[6] = '{1'b0, 32'h8000_0000,  -1, 1, 1'b0, 4'd15, 16'd1};
    tbl[7] = '{1'b0, 32'h0000_0082,   5, 1, 1'b0, 4'd0,  16'd1};

    repeat (2) @(negedge clk);
    chk_eq("rst_ctrl", {28'd0, chk, busy, done, pass}, 32'd0);
    chk_eq("rst_err", 32'(err_count), 32'd0);
    chk_eq("rst_fail", {12'd0, fail_pat, fail_vec}, 32'd0);
    chk_eq("rst_src", {8'd0, src1, src2, src3}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run(tbl[i].stop, tbl[i].mm, tbl[i].ak, tbl[i].err, tbl[i].pass, tbl[i].fp, tbl[i].fv);

    for (int r = 0; r < 6; r++) begin
      r_stop = 1'($urandom_range(0, 1));
      r_mm   = $urandom & $urandom & $urandom;
      r_ak   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NVEC - 1)) : -1;
      model(r_stop, r_mm, r_ak, r_err_e, r_pass_e, r_fp, r_fv);
      run(r_stop, r_mm, r_ak, r_err_e, r_pass_e, r_fp, r_fv);
    end

    // abort while idle has no effect
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk_eq("abort_idle", {29'd0, chk, busy, done}, 32'd0);

    // reset in the middle of CHECK, then restart reproduces vector 0
    exp_ops(0, e1, e2, e3, m1, m2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (SC) @(negedge clk);
    chk_eq("chk_pre_rst", 32'(chk), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk_eq("rst_async_ctrl", {29'd0, chk, busy, done}, 32'd0);
    chk_eq("rst_async_src", {8'd0, src1, src2, src3}, 32'd0);
    chk_eq("rst_async_err", 32'(err_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_eq("restart_src1", 32'(src1), 32'(e1));
    chk_eq("restart_src2", 32'(src2), 32'(e2));
    chk_eq("restart_src3", 32'(src3), 32'(e3));
    #1 rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // start held high through DONE does not retrigger
    @(negedge clk); start = 1'b1;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_eq("done_hold", {29'd0, chk, busy, done}, 32'd1);
      @(negedge clk);
    end
    chk_eq("held_pass", 32'(pass), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk_eq("held_release", {29'd0, chk, busy, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
